rds_serializer: RTL
===================

RDS_SERIALIZER -- requirements
Module: rds_serializer

Interface
REQ-001 SHALL have parameter MSG_BYTES, default 52, meaning number of message bytes walked per cycle of the message (4 RDS groups of 13 bytes).
REQ-002 SHALL have parameter ADDR_BITS, default 9, meaning width of the message-memory read address.
REQ-003 SHALL have parameter GROUP_BYTES, default 13, meaning bytes per RDS group (104 bits).
REQ-004 Ports: clk  in  1  single clock; all logic is rising-edge on clk.
REQ-005 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: en  in  1  level; high runs the serializer, low returns it to IDLE.
REQ-007 Ports: bit_tick  in  1  one-cycle strobe at the RDS bit rate (1187.5 Hz); spacing is at least 4 clk cycles.
REQ-008 Ports: mem_addr  out  ADDR_BITS  registered read address into the message BRAM instruction port.
REQ-009 Ports: mem_data  in  8  BRAM read data, valid exactly one clk after mem_addr changes (registered BRAM read).
REQ-010 Ports: rds_bit  out  1  raw data bit currently being emitted, MSB of each byte first.
REQ-011 Ports: rds_diff  out  1  differentially encoded bit: rds_diff toggles when the emitted bit is 1.
REQ-012 Ports: bit_valid  out  1  one-cycle pulse, asserted the cycle after each emitted bit.
REQ-013 Ports: group_start  out  1  one-cycle pulse, coincident with bit_valid for bit 7 of a byte whose index is a multiple of GROUP_BYTES.
REQ-014 Ports: msg_wrap  out  1  one-cycle pulse, coincident with bit_valid for bit 0 of byte MSG_BYTES-1.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, PRIME, RUN.
REQ-016 IDLE: mem_addr=0, bit and byte counters 0. en=1 -> FETCH.
REQ-017 FETCH: one wait cycle for the BRAM read of byte 0. Transition -> PRIME.
REQ-018 PRIME: SHALL load mem_data into the shift register, set mem_addr=1, and transition -> RUN.
REQ-019 RUN: one cycle after entry, SHALL capture mem_data (next byte) into the prefetch register.
REQ-020 RUN, on bit_tick: SHALL register rds_bit = shift[7] and rds_diff = rds_diff XOR shift[7], shift left by one, increment the bit counter, and pulse bit_valid the following cycle.
REQ-021 On the tick that emits bit 0 (bit counter 7):
  - SHALL load the shift register from the prefetch register and reset the bit counter to 0.
  - SHALL advance the byte index modulo MSG_BYTES.
  - SHALL set mem_addr = (byte index + 1) mod MSG_BYTES.
  - SHALL refill the prefetch register one clk later.
REQ-022 Wrap: after byte MSG_BYTES-1, the byte index SHALL return to 0, and the prefetched byte SHALL be byte 0; output is continuous with no gap bit.
REQ-023 bit_tick outside RUN, and bit_tick in the PRIME cycle, SHALL be ignored (no bit emitted, no pulses).
REQ-024 en=0 in any state SHALL force IDLE at the next edge. Effects:
  - counters and mem_addr cleared;
  - rds_bit and rds_diff hold their values;
  - a bit_tick in the same cycle as the en deassertion is ignored.
REQ-025 A restart after en deassert SHALL begin at byte 0, bit 7. rds_diff SHALL continue from its held value (no reset of the encoder).
REQ-026 Byte index SHALL be ceil(log2(MSG_BYTES)) bits wide and zero-extended to ADDR_BITS on mem_addr; the bit counter SHALL be 3 bits.
REQ-027 The block SHALL NOT write memory; it uses only the read port.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the following, and hold them while low:
  - state IDLE;
  - mem_addr=0;
  - shift and prefetch registers 0;
  - counters 0;
  - rds_bit=0, rds_diff=0, bit_valid=0, group_start=0, msg_wrap=0.
REQ-029 Release of rst_n SHALL be sampled synchronously; the first FETCH occurs no earlier than the first edge after release with en=1.

Verification
REQ-030 Memory byte0=8'hA5, en=1, 8 ticks -> rds_bit 1,0,1,0,0,1,0,1; rds_diff 1,1,0,0,0,1,1,0; group_start only with the first bit_valid.
REQ-031 Memory bytes 0..51 = index value, 417 ticks -> the following SHALL hold:
  - msg_wrap on bit_valid #416 only;
  - group_start on bit_valid #1, #105, #209, #313, #417;
  - bit #417 = bit 7 of byte 0.
REQ-032 Minimum tick spacing of 4 clk across byte boundaries, bytes 8'hFF,8'h00 -> bits 8x1 then 8x0, no skipped or repeated bit, mem_addr steps 1->2 at the 8th tick.
REQ-033 en dropped mid-byte (after 3 ticks of 8'hA5) with a simultaneous bit_tick -> tick ignored, IDLE next clk, rds_diff held; re-enable -> stream restarts at 1,0,1 from byte 0.
REQ-034 rst_n asserted in RUN mid-byte -> all outputs 0 asynchronously (before next clk edge); ticks ignored until en restart sequence FETCH, PRIME, RUN.
REQ-035 bit_tick pulsed while in IDLE, FETCH and PRIME -> no bit_valid, no change to rds_bit or rds_diff.

Source files
------------

// File: rtl/rds_serializer.sv
// RDS bit serializer: walks a message BRAM byte by byte and emits raw and
// differentially encoded bits, MSB first, one per bit_tick.
module rds_serializer #(
  parameter int MSG_BYTES   = 52,
  parameter int ADDR_BITS   = 9,
  parameter int GROUP_BYTES = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 bit_tick,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_data,
  output logic                 rds_bit,
  output logic                 rds_diff,
  output logic                 bit_valid,
  output logic                 group_start,
  output logic                 msg_wrap
);

  localparam int BW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(MSG_BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PRIME = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           pref_q, pref_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [BW-1:0]        byte_q, byte_d;
  // fill_q[1] marks the cycle in which mem_data holds the byte for the
  // address written two edges earlier (address register + BRAM register).
  logic [1:0]           fill_q, fill_d;
  logic                 rbit_q, rbit_d;
  logic                 rdiff_q, rdiff_d;
  logic                 vld_q, vld_d;
  logic                 grp_q, grp_d;
  logic                 wrap_q, wrap_d;

  logic [BW-1:0]        byte_inc;
  logic                 byte_last;
  logic                 byte_is_grp;

  function automatic logic [BW-1:0] next_idx(input logic [BW-1:0] i);
    return (i == LAST_BYTE) ? '0 : i + BW'(1);
  endfunction

  assign byte_last   = (byte_q == LAST_BYTE);
  assign byte_inc    = next_idx(byte_q);
  assign byte_is_grp = ((int'(byte_q) % GROUP_BYTES) == 0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    pref_d  = pref_q;
    bcnt_d  = bcnt_q;
    byte_d  = byte_q;
    fill_d  = {fill_q[0], 1'b0};
    rbit_d  = rbit_q;
    rdiff_d = rdiff_q;
    vld_d   = 1'b0;
    grp_d   = 1'b0;
    wrap_d  = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      addr_d  = '0;
      bcnt_d  = '0;
      byte_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = S_PRIME;
        S_PRIME: begin
          shift_d   = mem_data;
          bcnt_d    = '0;
          byte_d    = '0;
          addr_d    = ADDR_BITS'(next_idx('0));
          fill_d[0] = 1'b1;
          state_d   = S_RUN;
        end
        default: begin
          if (fill_q[1]) pref_d = mem_data;
          if (bit_tick) begin
            rbit_d  = shift_q[7];
            rdiff_d = rdiff_q ^ shift_q[7];
            vld_d   = 1'b1;
            grp_d   = (bcnt_q == 3'd0) && byte_is_grp;
            wrap_d  = (bcnt_q == 3'd7) && byte_last;
            if (bcnt_q == 3'd7) begin
              // Bypass covers a refill landing on the same edge as the reload.
              shift_d   = fill_q[1] ? mem_data : pref_q;
              bcnt_d    = '0;
              byte_d    = byte_inc;
              addr_d    = ADDR_BITS'(next_idx(byte_inc));
              fill_d[0] = 1'b1;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              bcnt_d  = bcnt_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      pref_q  <= '0;
      bcnt_q  <= '0;
      byte_q  <= '0;
      fill_q  <= '0;
      rbit_q  <= 1'b0;
      rdiff_q <= 1'b0;
      vld_q   <= 1'b0;
      grp_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      pref_q  <= pref_d;
      bcnt_q  <= bcnt_d;
      byte_q  <= byte_d;
      fill_q  <= fill_d;
      rbit_q  <= rbit_d;
      rdiff_q <= rdiff_d;
      vld_q   <= vld_d;
      grp_q   <= grp_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mem_addr    = addr_q;
  assign rds_bit     = rbit_q;
  assign rds_diff    = rdiff_q;
  assign bit_valid   = vld_q;
  assign group_start = grp_q;
  assign msg_wrap    = wrap_q;

endmodule
